// File: rtl/display_arbiter.sv
// Two-requester arbiter for a shared 4-digit display. Ownership is bounded by a number of
// scan ticks, and every handover includes at least one blanked scan so no ghost digits appear.
module display_arbiter #(
    parameter int unsigned DIV        = 100000,
    parameter int unsigned HOLD_TICKS = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [15:0] digit_data,
    output logic        blank,
    output logic        scan_tick,
    output logic [1:0]  done
);

    localparam int unsigned CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(DIV - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic              last_owner;
    logic              last_owner_nxt;
    logic [1:0]        grant_nxt;
    logic [15:0]       digit_nxt;
    logic              blank_nxt;
    logic [1:0]        done_nxt;

    logic owner;
    logic expire;
    logic own_exit;
    logic winner;

    // The owner is encoded by the registered one-hot grant; valid only in OWN
    assign owner    = grant[1];
    assign expire   = scan_tick && (hold == HOLD_LAST);
    assign own_exit = !req[owner] || expire;
    // With both requesting, the requester that did not own last wins
    assign winner   = (req == 2'b11) ? ~last_owner : req[1];

    // Free-running prescaler; scan_tick is registered to line up with the terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            scan_tick <= 1'b0;
        end else begin
            cnt       <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            scan_tick <= (cnt == CNT_PRE);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req != 2'b00) state_nxt = OWN;
            OWN:  if (own_exit)     state_nxt = GAP;
            GAP:  if (scan_tick)    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values, registered below
    always_comb begin
        grant_nxt      = grant;
        digit_nxt      = digit_data;
        blank_nxt      = blank;
        done_nxt       = 2'b00;
        hold_nxt       = hold;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                grant_nxt = 2'b00;
                blank_nxt = 1'b1;
                digit_nxt = 16'h0000;
                hold_nxt  = '0;
                if (req != 2'b00) begin
                    grant_nxt = winner ? 2'b10 : 2'b01;
                    blank_nxt = 1'b0;
                end
            end
            OWN: begin
                if (own_exit) begin
                    grant_nxt      = 2'b00;
                    blank_nxt      = 1'b1;
                    digit_nxt      = 16'h0000;
                    last_owner_nxt = owner;
                    done_nxt       = owner ? 2'b10 : 2'b01;
                end else begin
                    blank_nxt = 1'b0;
                    digit_nxt = owner ? data1 : data0;
                    if (scan_tick) hold_nxt = hold + HOLD_W'(1);
                end
            end
            default: begin
                grant_nxt = 2'b00;
                blank_nxt = 1'b1;
                digit_nxt = 16'h0000;
            end
        endcase
    end

    // Registered outputs and arbitration state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= 2'b00;
            digit_data <= 16'h0000;
            blank      <= 1'b1;
            done       <= 2'b00;
            hold       <= '0;
            last_owner <= 1'b1;
        end else begin
            grant      <= grant_nxt;
            digit_data <= digit_nxt;
            blank      <= blank_nxt;
            done       <= done_nxt;
            hold       <= hold_nxt;
            last_owner <= last_owner_nxt;
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with DIV=4, HOLD_TICKS=3; expected values are hand-derived
// from the cycle count since the last reset release.
module tb_display_arbiter;

    localparam int unsigned DIV        = 4;
    localparam int unsigned HOLD_TICKS = 3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  req     = 2'b00;
    logic [15:0] data0   = 16'h0000;
    logic [15:0] data1   = 16'h0000;
    logic [1:0]  grant;
    logic [15:0] digit_data;
    logic        blank;
    logic        scan_tick;
    logic [1:0]  done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    display_arbiter #(
        .DIV        (DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .grant      (grant),
        .digit_data (digit_data),
        .blank      (blank),
        .scan_tick  (scan_tick),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one edge and check the invariants that hold in every cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check("scan_tick", 32'(scan_tick), 32'((cyc % 4) == 3));
        check("grant_onehot", 32'(grant == 2'b11), 32'd0);
        check("done_grant_overlap", 32'(done & grant), 32'd0);
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    // Assert reset away from the clock edge, check the forced values, release on a negedge
    task automatic reset_pulse();
        reset_n = 1'b0;
        #2;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_digit", 32'(digit_data), 32'h0);
        check("rst_tick", 32'(scan_tick), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        data0 = 16'h5A5A;
        data1 = 16'h1234;
        #1;
        reset_pulse();

        // Idle: ticks every 4th cycle, display blanked and unowned
        for (int k = 0; k < 12; k++) begin
            step();
            check("idle_grant", 32'(grant), 32'h0);
            check("idle_blank", 32'(blank), 32'h1);
        end

        // Both requesting from reset: requester 0 wins, expires on third tick
        req = 2'b11;
        reset_pulse();
        step_to(1);
        check("t2_grant", 32'(grant), 32'h1);
        check("t2_blank", 32'(blank), 32'h0);
        check("t2_digit_lat", 32'(digit_data), 32'h0);
        step_to(2);
        check("t2_digit", 32'(digit_data), 32'h5A5A);
        step_to(11);
        check("t2_hold_grant", 32'(grant), 32'h1);
        check("t2_hold_done", 32'(done), 32'h0);
        step_to(12);
        check("t2_exp_grant", 32'(grant), 32'h0);
        check("t2_exp_done", 32'(done), 32'h1);
        check("t2_exp_blank", 32'(blank), 32'h1);
        check("t2_exp_digit", 32'(digit_data), 32'h0);
        step_to(13);
        check("t2_done_pulse", 32'(done), 32'h0);
        step_to(16);
        check("t2_gap_grant", 32'(grant), 32'h0);
        step_to(17);
        check("t2_rr_grant", 32'(grant), 32'h2);
        check("t2_rr_blank", 32'(blank), 32'h0);

        // Owner 1: live data tracking, non-owner data ignored
        step_to(18);
        check("t3_digit_a", 32'(digit_data), 32'h1234);
        data0 = 16'hFFFF;
        step_to(19);
        check("t3_digit_b", 32'(digit_data), 32'h1234);
        data1 = 16'hABCD;
        step_to(20);
        check("t3_digit_c", 32'(digit_data), 32'hABCD);
        step_to(27);
        check("t3_hold_grant", 32'(grant), 32'h2);
        check("t3_hold_done", 32'(done), 32'h0);
        step_to(28);
        check("t3_exp_done", 32'(done), 32'h2);
        check("t3_exp_grant", 32'(grant), 32'h0);
        check("t3_exp_digit", 32'(digit_data), 32'h0);
        req = 2'b01;
        step_to(29);
        check("t3_done_pulse", 32'(done), 32'h0);
        step_to(32);
        check("t3_gap_ignores_req", 32'(grant), 32'h0);
        step_to(33);
        check("t4_grant", 32'(grant), 32'h1);
        step_to(34);
        check("t4_digit", 32'(digit_data), 32'hFFFF);

        // Owner 0 drops request after one tick
        step_to(37);
        check("t4_pre_drop", 32'(grant), 32'h1);
        req = 2'b00;
        step_to(38);
        check("t4_drop_grant", 32'(grant), 32'h0);
        check("t4_drop_done", 32'(done), 32'h1);
        check("t4_drop_blank", 32'(blank), 32'h1);
        check("t4_drop_digit", 32'(digit_data), 32'h0);
        step_to(39);
        check("t4_done_pulse", 32'(done), 32'h0);
        step_to(40);
        req = 2'b10;
        step_to(41);
        check("t5_grant", 32'(grant), 32'h2);

        // Request drop coincides with the expiring tick: one exit, one gap
        step_to(51);
        check("t5_hold_grant", 32'(grant), 32'h2);
        req = 2'b00;
        step_to(52);
        check("t5_exit_done", 32'(done), 32'h2);
        check("t5_exit_grant", 32'(grant), 32'h0);
        req = 2'b01;
        step_to(53);
        check("t5_done_a", 32'(done), 32'h0);
        step_to(54);
        check("t5_done_b", 32'(done), 32'h0);
        step_to(56);
        check("t5_gap_grant", 32'(grant), 32'h0);
        step_to(57);
        check("t5_regrant", 32'(grant), 32'h1);

        // Reset in the middle of owner 1's hold
        req = 2'b10;
        step_to(58);
        check("t6_done", 32'(done), 32'h1);
        step_to(60);
        check("t6_gap_grant", 32'(grant), 32'h0);
        step_to(61);
        check("t6_grant", 32'(grant), 32'h2);
        step_to(62);
        check("t6_digit", 32'(digit_data), 32'hABCD);
        req = 2'b11;
        reset_pulse();
        step_to(1);
        check("t6_post_grant", 32'(grant), 32'h1);
        check("t6_post_done", 32'(done), 32'h0);
        step_to(2);
        check("t6_post_digit", 32'(digit_data), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
